// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready front-end for a 64 x 128-bit single-port
// bit-write SRAM macro. Requests issue straight to the macro pins, the
// access is tracked for one cycle, and its response is queued in an
// in-order FIFO with registered head outputs.
module sram_req_ctrl #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned STRB_W    = 16,
  parameter int unsigned RSP_DEPTH = 3
) (
  input  logic              CLK,
  input  logic              RSTN,
  // request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  // macro pins (active-low controls)
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [DATA_W-1:0] sram_bwen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned LAST  = RSP_DEPTH - 1;

  // One queued response: kind plus read data (zero for write acknowledges).
  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic             fire;
  logic             push;
  logic             pop;
  logic             infl_v;
  logic             infl_write;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] occ_n;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_n;
  logic             head_v_n;
  rsp_t             head_n;
  rsp_t             push_ent;
  rsp_t             mem [RSP_DEPTH];

  // Circular pointer advance with wrap at the last FIFO slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LAST)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit: only registered state (and reset) gates acceptance, so a pop
  // frees a slot one cycle later and a push can never meet a full FIFO.
  assign req_ready = RSTN && ((SUM_W'(occ) + SUM_W'(infl_v)) < SUM_W'(RSP_DEPTH));
  assign fire      = req_valid && req_ready;
  assign push      = infl_v;
  assign pop       = rsp_valid && rsp_ready;

  // Macro pins pass the request through; only chip enable depends on fire.
  assign sram_cen = ~fire;
  assign sram_wen = ~req_write;
  assign sram_a   = req_addr;
  assign sram_d   = req_wdata;

  // Expand byte strobes into the active-low per-bit mask; reads mask all bits.
  always_comb begin
    sram_bwen = '1;
    if (req_write) begin
      for (int i = 0; i < STRB_W; i++) begin
        sram_bwen[8*i +: 8] = {8{~req_wstrb[i]}};
      end
    end
  end

  // Response for the in-flight access; sram_q is looked at only for reads.
  always_comb begin
    push_ent       = '0;
    push_ent.write = infl_write;
    if (infl_v && !infl_write) begin
      push_ent.data = sram_q;
    end
  end

  // FIFO bookkeeping and next head; an empty FIFO forwards the push directly.
  always_comb begin
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    occ_n    = occ;
    head_v_n = 1'b0;
    head_n   = '0;
    if (pop) begin
      rd_ptr_n = ptr_inc(rd_ptr);
    end
    if (push) begin
      wr_ptr_n = ptr_inc(wr_ptr);
    end
    case ({push, pop})
      2'b10:   occ_n = occ + CNT_W'(1);
      2'b01:   occ_n = occ - CNT_W'(1);
      default: occ_n = occ;
    endcase
    if (occ_n != '0) begin
      head_v_n = 1'b1;
      if (push && (occ == CNT_W'(pop))) begin
        head_n = push_ent;
      end else begin
        head_n = mem[rd_ptr_n];
      end
    end
  end

  // FIFO storage; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_ent;
    end
  end

  // Control state and registered response head; synchronous reset drops all.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      infl_v     <= 1'b0;
      infl_write <= 1'b0;
      occ        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      infl_v     <= fire;
      infl_write <= fire && req_write;
      occ        <= occ_n;
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      rsp_valid  <= head_v_n;
      rsp_write  <= head_n.write;
      rsp_rdata  <= head_n.data;
    end
  end

  // A push must always find a free slot.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
    push |-> (occ < CNT_W'(RSP_DEPTH)));

  // The head register mirrors occupancy.
  a_head_valid: assert property (@(posedge CLK) disable iff (!RSTN)
    rsp_valid == (occ != '0));

  // A stalled head holds its payload.
  a_head_stable: assert property (@(posedge CLK) disable iff (!RSTN)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_write) && $stable(rsp_rdata)));

endmodule
